dbg_mem_master: RTL and testbench
=================================

Name: dbg_mem_master

Overview:
- Initiator for the debug port (port B) of the 64 KB data memory at window 0x1000_0000–0x1000_FFFF.
- Accepts burst commands from the debug host side (console/loader logic) over a valid/ready channel.
- Drives dbg_address/dbg_read/dbg_write/dbg_in and returns read words over a valid/ready response channel.
- Replaces ad-hoc single-word debug pokes with bursts that auto-increment the address.

Parameters:
- RD_LATENCY, 1: cycles from dbg_address/dbg_read presentation to valid dbg_out (1..3).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  start byte address; bits [1:0] ignored
- cmd_len  in  8  burst length minus one (0 → 1 word, 255 → 256 words)
- wr_valid  in  1  write word present
- wr_ready  out  1  write word consumed when wr_valid & wr_ready
- wr_data  in  32  write word
- rd_valid  out  1  read word present
- rd_ready  in  1  read word taken when rd_valid & rd_ready
- rd_data  out  32  read word
- rd_last  out  1  marks the final word of a read burst (qualified by rd_valid)
- busy  out  1  high in every state except IDLE
- err  out  1  sticky range error for the current/last command
- dbg_address  out  32  memory debug address
- dbg_read  out  1  memory debug read enable
- dbg_write  out  1  memory debug write enable
- dbg_in  out  32  memory debug write data
- dbg_out  in  32  memory debug read data

Behaviour:
- Reset values: all outputs 0, except that cmd_ready follows the IDLE state, so it goes to 1 when reset deasserts. Reset asserted mid-burst aborts immediately to IDLE; no partial state survives.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch the address and length: addr_q = {cmd_addr[31:2], 2'b00}, remaining = cmd_len.
  - err <= (cmd_addr[31:16] != 16'h1000). This clears the error from any previous command.
  - Next state: WRITE if cmd_write = 1, otherwise RD_ISSUE.
- WRITE:
  - wr_ready = 1.
  - dbg_write = wr_valid & ~err, combinationally in the same cycle.
  - dbg_address = addr_q; dbg_in = wr_data.
  - Each handshake:
    - If remaining == 0, go to IDLE.
    - Otherwise remaining--, and addr_q[15:2]++.
  - One word per cycle at full rate. A stall (wr_valid = 0) holds all state.
- RD_ISSUE:
  - Lasts one cycle.
  - dbg_read = 1 and dbg_address = addr_q.
  - Load the latency counter with RD_LATENCY-1, then go to RD_WAIT.
  - If RD_LATENCY == 1, the counter is loaded with 0, so RD_WAIT lasts one cycle.
- RD_WAIT:
  - dbg_address is held at addr_q; dbg_read = 0.
  - When the counter reaches 0, capture rd_data <= (err ? 0 : dbg_out) and go to RD_RESP.
- RD_RESP:
  - rd_valid = 1; rd_last = (remaining == 0). rd_data is held stable until the handshake.
  - On handshake:
    - If remaining == 0, go to IDLE.
    - Otherwise remaining--, addr_q[15:2]++, and go to RD_ISSUE.
- Read throughput: one word per (RD_LATENCY + 2) cycles, given rd_ready held high.
- Address increment:
  - Only bits [15:2] count, modulo 2^14, so 0x1000_FFFC wraps to 0x1000_0000.
  - Bits [31:16] and [1:0] never change during a burst.
- Range error (err = 1):
  - The burst still runs to completion, so the host protocol never deadlocks.
  - Write words are consumed but dbg_write stays 0.
  - Read words return 0x0000_0000.
- Idle outputs: dbg_in = 0, dbg_address = 0 and dbg_read = dbg_write = 0 in IDLE.
- wr_valid outside WRITE and rd_ready outside RD_RESP are ignored.
- cmd_ready = 0 whenever busy = 1; a new command is not accepted in the cycle the previous one completes.

Test Plan:
- Reset mid-write burst (cmd_len = 7 at 0x1000_0000, reset asserted after the 3rd word) → all outputs 0 asynchronously; cmd_ready = 1 after release; memory holds only the 3 words.
- Write cmd_addr = 0x1000_0103, cmd_len = 3, data 0x11,0x22,0x33,0x44 with wr_valid always high → 4 consecutive dbg_write pulses at 0x1000_0100, 0x104, 0x108, 0x10C; then IDLE.
- Read back the same 4 words with rd_ready toggled 1/0 → rd_data 0x11,0x22,0x33,0x44 in order; rd_last only on 0x44; each word held stable while rd_ready = 0.
- Wrap: write cmd_addr = 0x1000_FFF8, cmd_len = 2 → addresses 0x1000_FFF8, 0x1000_FFFC, 0x1000_0000.
- Range error: write cmd_addr = 0x2000_0000, cmd_len = 1 → err = 1, 2 words consumed, dbg_write never asserted. A subsequent read of 1 word at the same address → rd_data = 0. A following valid command clears err.
- RD_LATENCY = 3 build: read of 1 word → dbg_read at cycle N, capture at N+3, rd_valid from N+4.

Source files
------------

// File: rtl/dbg_mem_master_if.sv
// Command, write-data, read-response and memory debug-port signals of dbg_mem_master.
// The master modport is the burst engine; the slave modport is the host/memory side.
interface dbg_mem_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;

  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;

  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;

  logic        busy;
  logic        err;

  logic [31:0] dbg_address;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_in;
  logic [31:0] dbg_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  dbg_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    output busy, err,
    output dbg_address, dbg_read, dbg_write, dbg_in
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output dbg_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    input  busy, err,
    input  dbg_address, dbg_read, dbg_write, dbg_in
  );
endinterface

// File: rtl/dbg_mem_master.sv
// Burst initiator for the debug port of the 64 KB data memory window 0x1000_0000-0x1000_FFFF.
// Address auto-increments within bits [15:2]; out-of-window bursts run to completion harmlessly.
module dbg_mem_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input logic            clock,
  input logic            reset,
  dbg_mem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [7:0]  remaining;
  logic [1:0]  lat_cnt;
  logic        err_q;
  logic [31:0] rd_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.cmd_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.rd_valid    = 1'b0;
    bus.rd_last     = 1'b0;
    bus.busy        = (state != IDLE);
    bus.dbg_address = 32'h0;
    bus.dbg_read    = 1'b0;
    bus.dbg_write   = 1'b0;
    bus.dbg_in      = 32'h0;
    case (state)
      IDLE: begin
        // cmd_ready only rises once reset is released
        bus.cmd_ready = ~reset;
        if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : RD_ISSUE;
      end
      WRITE: begin
        bus.wr_ready    = 1'b1;
        bus.dbg_address = addr_q;
        bus.dbg_in      = bus.wr_data;
        bus.dbg_write   = bus.wr_valid & ~err_q;
        if (bus.wr_valid && remaining == 8'd0) state_nxt = IDLE;
      end
      RD_ISSUE: begin
        bus.dbg_address = addr_q;
        bus.dbg_read    = 1'b1;
        state_nxt       = RD_WAIT;
      end
      RD_WAIT: begin
        bus.dbg_address = addr_q;
        if (lat_cnt == 2'd0) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        bus.dbg_address = addr_q;
        bus.rd_valid    = 1'b1;
        bus.rd_last     = (remaining == 8'd0);
        if (bus.rd_ready) state_nxt = (remaining == 8'd0) ? IDLE : RD_ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= 32'h0;
      remaining <= 8'h0;
      lat_cnt   <= 2'd0;
      err_q     <= 1'b0;
      rd_data_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q    <= bus.cmd_addr & ~32'h3;
            remaining <= bus.cmd_len;
            err_q     <= (bus.cmd_addr[31:16] != 16'h1000);
          end
        end
        WRITE: begin
          if (bus.wr_valid && remaining != 8'd0) begin
            remaining    <= remaining - 8'd1;
            addr_q[15:2] <= addr_q[15:2] + 14'd1;
          end
        end
        RD_ISSUE: lat_cnt <= LAT_LOAD;
        RD_WAIT: begin
          // out-of-window reads return zero rather than whatever the port drives
          if (lat_cnt == 2'd0) rd_data_q <= err_q ? 32'h0 : bus.dbg_out;
          else                 lat_cnt   <= lat_cnt - 2'd1;
        end
        RD_RESP: begin
          if (bus.rd_ready && remaining != 8'd0) begin
            remaining    <= remaining - 8'd1;
            addr_q[15:2] <= addr_q[15:2] + 14'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_dbg_mem_master.sv
// Bench for dbg_mem_master: directed and random bursts checked against a word-level memory model.
// A second instance built with RD_LATENCY = 3 checks read timing.
module tb_dbg_mem_master;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dbg_mem_master_if if1();
  dbg_mem_master_if if3();

  dbg_mem_master #(.RD_LATENCY(LAT))  u_dut  (.clock(clock), .reset(reset), .bus(if1));
  dbg_mem_master #(.RD_LATENCY(LAT3)) u_dut3 (.clock(clock), .reset(reset), .bus(if3));

  // memory behind the debug port of u_dut, and a fixed-pattern memory for u_dut3
  logic [31:0] mem [16384];
  logic [31:0] rd_pipe;
  logic        init_mem = 1'b1;
  logic [31:0] p3 [3];

  function automatic logic [31:0] pat3(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 16384; i++) mem[i] <= {16'hC0DE, 16'(i)};
    end else if (if1.dbg_write) begin
      mem[if1.dbg_address[15:2]] <= if1.dbg_in;
    end
    rd_pipe <= if1.dbg_read ? mem[if1.dbg_address[15:2]] : 32'h0;
    p3[0]   <= if3.dbg_read ? pat3(if3.dbg_address) : 32'h0;
    p3[1]   <= p3[0];
    p3[2]   <= p3[1];
  end

  assign if1.dbg_out = rd_pipe;
  assign if3.dbg_out = p3[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [16384];
  logic [31:0] waddr_log[$];
  logic [31:0] rdata_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] word_addr(input logic [31:0] base, input int i);
    logic [13:0] w;
    w = base[15:2] + 14'(i);
    return {base[31:16], w, 2'b00};
  endfunction

  function automatic bit out_of_window(input logic [31:0] a);
    return a[31:16] != 16'h1000;
  endfunction

  task automatic send_cmd(input bit wr, input logic [31:0] addr, input int len);
    if1.cmd_valid = 1'b1;
    if1.cmd_write = wr;
    if1.cmd_addr  = addr;
    if1.cmd_len   = 8'(len);
    #1;
    chk("cmd_ready_idle", if1.cmd_ready, 1'b1);
    tick();
    if1.cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", if1.busy, 1'b1);
    chk("cmd_ready_busy", if1.cmd_ready, 1'b0);
    chk("err_after_accept", if1.err, out_of_window(addr));
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int stall_pct,
                          input logic [31:0] wd[$], output int cycles);
    bit          e;
    logic [31:0] base;
    logic [31:0] wa;
    int          sent;
    bit          v;
    e    = out_of_window(addr);
    base = addr & ~32'h3;
    waddr_log.delete();
    send_cmd(1'b1, addr, len);
    sent   = 0;
    cycles = 0;
    while (sent <= len && cycles < 2000) begin
      v = ($urandom_range(99) >= stall_pct);
      if1.wr_valid = v;
      if1.wr_data  = wd[sent];
      #1;
      wa = word_addr(base, sent);
      chk("wr_ready", if1.wr_ready, 1'b1);
      chk("wr_addr", if1.dbg_address, wa);
      if (v) begin
        chk("dbg_write", if1.dbg_write, !e);
        chk("dbg_in", if1.dbg_in, wd[sent]);
        if (if1.dbg_write) waddr_log.push_back(if1.dbg_address);
        if (!e) exp_mem[wa[15:2]] = wd[sent];
        sent++;
      end else begin
        chk("dbg_write_stall", if1.dbg_write, 1'b0);
      end
      tick();
      cycles++;
    end
    if1.wr_valid = 1'b0;
    #1;
    chk("wr_words_consumed", sent, len + 1);
    chk("idle_after_write", {if1.busy, if1.cmd_ready}, 2'b01);
    chk("idle_dbg_addr", if1.dbg_address, 32'h0);
    chk("idle_dbg_in", if1.dbg_in, 32'h0);
    chk("err_sticky_wr", if1.err, e);
  endtask

  // ready_mode: 0 = always ready, 1 = toggles 0/1, 2 = random
  task automatic do_read(input logic [31:0] addr, input int len, input int ready_mode,
                         output int cycles);
    bit          e;
    logic [31:0] base;
    logic [31:0] wa;
    logic [31:0] expd;
    int          got;
    int          issues;
    bit          r;
    e    = out_of_window(addr);
    base = addr & ~32'h3;
    rdata_log.delete();
    send_cmd(1'b0, addr, len);
    got    = 0;
    issues = 0;
    cycles = 0;
    while (got <= len && cycles < 3000) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = cycles[0];
        default: r = 1'($urandom_range(1));
      endcase
      if1.rd_ready = r;
      #1;
      wa   = word_addr(base, got);
      expd = e ? 32'h0 : exp_mem[wa[15:2]];
      if (if1.dbg_read) begin
        issues++;
        chk("rd_issue_addr", if1.dbg_address, wa);
      end
      if (if1.rd_valid) begin
        chk("rd_data", if1.rd_data, expd);
        chk("rd_last", if1.rd_last, got == len);
        if (r) begin
          rdata_log.push_back(if1.rd_data);
          got++;
        end
      end
      tick();
      cycles++;
    end
    if1.rd_ready = 1'b0;
    #1;
    chk("rd_words_returned", got, len + 1);
    chk("rd_issue_count", issues, len + 1);
    chk("idle_after_read", {if1.busy, if1.cmd_ready, if1.rd_valid}, 3'b010);
    chk("err_sticky_rd", if1.err, e);
  endtask

  initial begin
    logic [31:0] wd[$];
    logic [31:0] a;
    int          cyc;
    int          len;
    int          n_issue;
    int          n_valid;
    logic [31:0] d3;

    if1.cmd_valid = 1'b0; if1.cmd_write = 1'b0; if1.cmd_addr = 32'h0; if1.cmd_len = 8'h0;
    if1.wr_valid  = 1'b0; if1.wr_data   = 32'h0; if1.rd_ready = 1'b0;
    if3.cmd_valid = 1'b0; if3.cmd_write = 1'b0; if3.cmd_addr = 32'h0; if3.cmd_len = 8'h0;
    if3.wr_valid  = 1'b0; if3.wr_data   = 32'h0; if3.rd_ready = 1'b0;
    for (int i = 0; i < 16384; i++) exp_mem[i] = {16'hC0DE, 16'(i)};

    // reset state
    tick(); tick();
    chk("rst_ctrl", {if1.cmd_ready, if1.wr_ready, if1.rd_valid, if1.rd_last,
                     if1.busy, if1.err, if1.dbg_read, if1.dbg_write}, 8'h00);
    chk("rst_dbg_addr", if1.dbg_address, 32'h0);
    chk("rst_dbg_in", if1.dbg_in, 32'h0);
    chk("rst_rd_data", if1.rd_data, 32'h0);
    reset    = 1'b0;
    init_mem = 1'b0;
    #1;
    chk("cmd_ready_after_rst", if1.cmd_ready, 1'b1);
    tick();

    // reset in the middle of an 8-word write burst, after 3 words
    send_cmd(1'b1, 32'h1000_0000, 7);
    for (int i = 0; i < 3; i++) begin
      if1.wr_valid = 1'b1;
      if1.wr_data  = 32'hA000_0000 + 32'(i);
      exp_mem[i]   = 32'hA000_0000 + 32'(i);
      tick();
    end
    d3 = 32'hA000_0003;
    if1.wr_data = d3;
    #1;
    chk("pre_rst_dbg_write", if1.dbg_write, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {if1.cmd_ready, if1.wr_ready, if1.rd_valid, if1.busy,
                           if1.err, if1.dbg_read, if1.dbg_write}, 7'h00);
    chk("async_rst_addr", if1.dbg_address, 32'h0);
    chk("async_rst_din", if1.dbg_in, 32'h0);
    if1.wr_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_rst2", if1.cmd_ready, 1'b1);
    chk("busy_after_rst2", if1.busy, 1'b0);
    tick();
    do_read(32'h1000_0000, 3, 0, cyc);

    // unaligned start, full-rate write
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_write(32'h1000_0103, 3, 0, wd, cyc);
    chk("wr_full_rate_cycles", cyc, 4);
    chk("wr_log_len", waddr_log.size(), 4);
    if (waddr_log.size() == 4) begin
      chk("wr_addr0", waddr_log[0], 32'h1000_0100);
      chk("wr_addr1", waddr_log[1], 32'h1000_0104);
      chk("wr_addr2", waddr_log[2], 32'h1000_0108);
      chk("wr_addr3", waddr_log[3], 32'h1000_010C);
    end

    // read back with rd_ready toggling
    do_read(32'h1000_0100, 3, 1, cyc);
    chk("rd_log_len", rdata_log.size(), 4);
    if (rdata_log.size() == 4) begin
      chk("rd_word0", rdata_log[0], 32'h11);
      chk("rd_word1", rdata_log[1], 32'h22);
      chk("rd_word2", rdata_log[2], 32'h33);
      chk("rd_word3", rdata_log[3], 32'h44);
    end

    // address wrap within the window
    wd = '{32'hF1F1_0001, 32'hF1F1_0002, 32'hF1F1_0003};
    do_write(32'h1000_FFF8, 2, 0, wd, cyc);
    chk("wrap_log_len", waddr_log.size(), 3);
    if (waddr_log.size() == 3) begin
      chk("wrap_addr0", waddr_log[0], 32'h1000_FFF8);
      chk("wrap_addr1", waddr_log[1], 32'h1000_FFFC);
      chk("wrap_addr2", waddr_log[2], 32'h1000_0000);
    end
    do_read(32'h1000_FFF8, 2, 0, cyc);
    chk("rd_throughput_cycles", cyc, 3 * (LAT + 2));

    // out-of-window burst, then a good command clears err
    wd = '{32'hBAD0_0001, 32'hBAD0_0002};
    do_write(32'h2000_0000, 1, 0, wd, cyc);
    chk("err_wr_cycles", cyc, 2);
    chk("err_no_writes", waddr_log.size(), 0);
    do_read(32'h2000_0000, 0, 0, cyc);
    chk("err_rd_len", rdata_log.size(), 1);
    if (rdata_log.size() == 1) chk("err_rd_zero", rdata_log[0], 32'h0);
    do_read(32'h1000_0000, 0, 0, cyc);
    chk("err_cleared", if1.err, 1'b0);

    // random bursts: write then read back, with stalls and back-pressure
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(7))
        0:       a = {16'($urandom_range(16'hFFFF)) | 16'h4000, 16'($urandom)};
        1:       a = 32'h1000_FFF0 + 32'($urandom_range(15));
        default: a = {16'h1000, 16'($urandom)};
      endcase
      len = $urandom_range(6);
      wd.delete();
      for (int i = 0; i <= len; i++) wd.push_back($urandom);
      do_write(a, len, 30, wd, cyc);
      do_read(a, len, 2, cyc);
    end

    // RD_LATENCY = 3 instance: issue at N, capture at N+3, rd_valid from N+4
    if3.cmd_valid = 1'b1;
    if3.cmd_write = 1'b0;
    if3.cmd_addr  = 32'h1000_0040;
    if3.cmd_len   = 8'd0;
    if3.rd_ready  = 1'b1;
    tick();
    if3.cmd_valid = 1'b0;
    n_issue = -1;
    n_valid = -1;
    for (int c = 0; c < 50 && n_valid < 0; c++) begin
      if (if3.dbg_read && n_issue < 0) n_issue = c;
      if (if3.rd_valid) begin
        n_valid = c;
        chk("lat3_rd_data", if3.rd_data, pat3(32'h1000_0040));
        chk("lat3_rd_last", if3.rd_last, 1'b1);
      end
      tick();
    end
    chk("lat3_issue_cycle", n_issue, 0);
    chk("lat3_valid_cycle", n_valid, 4);
    chk("lat3_idle", {if3.busy, if3.cmd_ready}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
